proc_prog_feeder: RTL and testbench

//  Instruction source for the 16-bit proc datapath. Stores a short program loaded by a host,

---
 rtl/proc_prog_feeder.sv | 244 ++++++++++++++++++++++++
 tb/tb_proc_prog_feeder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_prog_feeder.sv
// ---------------------------------------------------------------------------
// proc_prog_feeder
//
// Instruction source for the 16-bit proc datapath. A host loads a short
// program into a small memory, then pulses start. The feeder presents each
// instruction word on DIN in the proc's time step 0 and each MVI immediate in
// time step 1. It follows the proc's Done pulses so that every issue lines up
// with a fresh step 0.
//
// Parameters
//   DEPTH    program memory words (power of two, DEPTH == 2**AW)
//   AW       program memory address width
//   TIMEOUT  longest run of WAIT cycles without Done before ERROR
//
// Ports
//   Clock      in   1     single clock, everything on posedge
//   Resetn     in   1     synchronous active-low reset (memory not cleared)
//   load_en    in   1     write load_data to mem[load_addr] (IDLE/HALT/ERROR only)
//   load_addr  in   AW    program memory write address
//   load_data  in   16    program word {7'b0, I[2:0], X[2:0], Y[2:0]} or immediate
//   prog_len   in   AW+1  words to issue (immediates count), sampled on start
//   start      in   1     begin execution at address 0 (ignored while busy)
//   Done       in   1     proc Done, combinational from the proc
//   DIN        out  16    word presented to the proc (0 = mv R0,R0 filler)
//   Run        out  1     high while a real program word is on DIN
//   pc         out  AW    address of the next word to issue
//   busy       out  1     high in ARM/ISSUE/IMM/WAIT
//   halted     out  1     high in HALT
//   error      out  1     high in ERROR
// ---------------------------------------------------------------------------
module proc_prog_feeder #(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 4
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          Done,
  output logic [15:0]   DIN,
  output logic          Run,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          error
);

  // Word counter is one bit wider than prog_len: an MVI immediate issued on the
  // last counted slot can push the count one past prog_len.
  localparam int CW  = AW + 2;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_IMM   = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_HALT  = 3'd5;
  localparam logic [2:0] ST_ERROR = 3'd6;

  localparam logic [AW-1:0]  PC_ONE  = AW'(1'b1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1'b1);
  localparam logic [WDW-1:0] WD_ONE  = WDW'(1'b1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  // Opcode field I = word[8:6]; any word with bit 8 set is a HALT marker.
  function automatic logic is_halt_marker(input logic [15:0] w);
    return w[8];
  endfunction

  function automatic logic is_mvi(input logic [15:0] w);
    return (w[8:6] == 3'b001);
  endfunction

  function automatic logic is_busy_state(input logic [2:0] s);
    logic b;
    case (s)
      ST_ARM, ST_ISSUE, ST_IMM, ST_WAIT: b = 1'b1;
      default:                           b = 1'b0;
    endcase
    return b;
  endfunction

  logic [15:0]    mem_r [DEPTH];
  logic [2:0]     state_r;
  logic [2:0]     state_s;
  logic [AW-1:0]  pc_s;
  logic [CW-1:0]  count_r;
  logic [CW-1:0]  count_s;
  logic [CW-1:0]  count_inc_s;
  logic [CW-1:0]  len_ext_s;
  logic [AW:0]    len_r;
  logic [AW:0]    len_s;
  logic [WDW-1:0] wd_r;
  logic [WDW-1:0] wd_s;
  logic [15:0]    word_s;
  logic           can_start_s;
  logic           wr_en_s;

  assign word_s      = mem_r[pc];
  assign count_inc_s = count_r + CNT_ONE;
  assign len_ext_s   = {1'b0, len_r};
  assign can_start_s = (state_r == ST_IDLE) || (state_r == ST_HALT) || (state_r == ST_ERROR);
  assign wr_en_s     = load_en && can_start_s;

  // Program memory write port; deliberately unreset so programs survive Resetn.
  always_ff @(posedge Clock) begin
    if (wr_en_s) begin
      mem_r[load_addr] <= load_data;
    end
  end

  // Next-state, pc, word count and watchdog decode.
  always_comb begin
    state_s = state_r;
    pc_s    = pc;
    count_s = count_r;
    len_s   = len_r;
    wd_s    = wd_r;
    case (state_r)
      ST_IDLE, ST_HALT, ST_ERROR: begin
        if (start) begin
          len_s   = prog_len;
          pc_s    = {AW{1'b0}};
          count_s = {CW{1'b0}};
          wd_s    = {WDW{1'b0}};
          if (prog_len == {(AW+1){1'b0}}) begin
            state_s = ST_HALT;
          end else begin
            state_s = ST_ARM;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_ARM: begin
        // A Done here means the proc returns to step 0 next cycle.
        if (Done) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_ARM;
        end
      end
      ST_ISSUE: begin
        if (Done) begin
          // The proc should be in step 0; a Done now means we lost lock.
          state_s = ST_ERROR;
        end else if (is_halt_marker(word_s)) begin
          state_s = ST_HALT;
        end else begin
          pc_s    = pc + PC_ONE;
          count_s = count_inc_s;
          wd_s    = {WDW{1'b0}};
          if (is_mvi(word_s)) begin
            state_s = ST_IMM;
          end else begin
            state_s = ST_WAIT;
          end
        end
      end
      ST_IMM: begin
        // The immediate is consumed in step 1, which is also the MVI Done cycle.
        pc_s    = pc + PC_ONE;
        count_s = count_inc_s;
        if (!Done) begin
          state_s = ST_ERROR;
        end else if (count_inc_s >= len_ext_s) begin
          state_s = ST_HALT;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (Done) begin
          if (count_r >= len_ext_s) begin
            state_s = ST_HALT;
          end else begin
            state_s = ST_ISSUE;
          end
        end else if (wd_r == WD_LAST) begin
          state_s = ST_ERROR;
        end else begin
          wd_s = wd_r + WD_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // DIN/Run follow the current state and the async memory read at pc.
  always_comb begin
    DIN = 16'h0000;
    Run = 1'b0;
    case (state_r)
      ST_ISSUE: begin
        if (is_halt_marker(word_s)) begin
          DIN = 16'h0000;
          Run = 1'b0;
        end else begin
          DIN = word_s;
          Run = 1'b1;
        end
      end
      ST_IMM: begin
        DIN = word_s;
        Run = 1'b1;
      end
      default: begin
        DIN = 16'h0000;
        Run = 1'b0;
      end
    endcase
  end

  // State and registered status outputs; status is decoded from the next state.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_r <= ST_IDLE;
      pc      <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
      len_r   <= {(AW+1){1'b0}};
      wd_r    <= {WDW{1'b0}};
      busy    <= 1'b0;
      halted  <= 1'b0;
      error   <= 1'b0;
    end else begin
      state_r <= state_s;
      pc      <= pc_s;
      count_r <= count_s;
      len_r   <= len_s;
      wd_r    <= wd_s;
      busy    <= is_busy_state(state_s);
      halted  <= (state_s == ST_HALT);
      error   <= (state_s == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_proc_prog_feeder.sv
// Bench for proc_prog_feeder: a small behavioural proc produces Done, a
// word-level program walker predicts the issued words, final pc and the proc
// register file; a negedge monitor pops expected words whenever Run is high.
module tb_proc_prog_feeder;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int BOUND = 2000;

  logic          Clock;
  logic          Resetn;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [15:0]   load_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          Done;
  logic [15:0]   DIN;
  logic          Run;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic          error;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  proc_prog_feeder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(4)) dut (
    .Clock(Clock), .Resetn(Resetn), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start), .Done(Done),
    .DIN(DIN), .Run(Run), .pc(pc), .busy(busy), .halted(halted), .error(error)
  );

  // ---------------- behavioural proc: T0 latch IR, mv/mvi done T1, add/sub done T3
  logic [15:0] preg [8];
  logic [1:0]  step;
  logic [8:0]  ir;
  logic [15:0] acc_a;
  logic [15:0] acc_g;
  logic        done_proc;
  logic        hold_done_low;

  always_comb done_proc = ((step == 2'd1) && (ir[8] || !ir[7])) ||
                          ((step == 2'd3) && (ir[8:7] == 2'b01));
  assign Done = done_proc && !hold_done_low;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      step  <= 2'd0;
      ir    <= 9'd0;
      acc_a <= 16'h0000;
      acc_g <= 16'h0000;
      for (int i = 0; i < 8; i++) preg[i] <= 16'h0000;
    end else begin
      step <= done_proc ? 2'd0 : step + 2'd1;
      case (step)
        2'd0: ir <= DIN[8:0];
        2'd1: begin
          case (ir[8:6])
            3'b000:         preg[ir[5:3]] <= preg[ir[2:0]];
            3'b001:         preg[ir[5:3]] <= DIN;
            3'b010, 3'b011: acc_a <= preg[ir[5:3]];
            default:        acc_a <= acc_a;
          endcase
        end
        2'd2: acc_g <= ir[6] ? (acc_a - preg[ir[2:0]]) : (acc_a + preg[ir[2:0]]);
        default: if (ir[8:7] == 2'b01) preg[ir[5:3]] <= acc_g;
      endcase
    end
  end

  // ---------------- reference state and scoreboard
  logic [15:0] mem_m [DEPTH];
  logic [15:0] ref_r [8];
  logic [15:0] exp_q [$];
  int          exp_pc;
  int          n_checks;
  int          n_fail;
  bit          mon_en;
  logic        prev_run;
  logic        prev_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every Run cycle must carry the next expected word, and every rise
  // of Run must directly follow a cycle in which Done was visible.
  always @(negedge Clock) begin
    if (!mon_en || !Resetn) begin
      prev_run  <= 1'b0;
      prev_done <= 1'b0;
    end else begin
      if (Run) begin
        if (exp_q.size() == 0) check("run_word_available", 32'(exp_q.size()), 32'd1);
        else check("din_word", {16'h0000, DIN}, {16'h0000, exp_q.pop_front()});
        if (!prev_run) check("run_after_done_gap", {31'd0, prev_done}, 32'd1);
      end
      prev_run  <= Run;
      prev_done <= Done;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_word(input int addr, input logic [15:0] data);
    load_en   = 1'b1;
    load_addr = AW'(addr);
    load_data = data;
    mem_m[addr] = data;
    tick();
    load_en = 1'b0;
  endtask

  task automatic reset_refs();
    for (int i = 0; i < 8; i++) ref_r[i] = 16'h0000;
    exp_q.delete();
  endtask

  // Word-level walk of the program: what gets issued, where pc ends, and what
  // the proc registers hold afterwards.
  task automatic plan(input int len);
    int cnt;
    int a;
    logic [15:0] w;
    cnt = 0;
    a   = 0;
    while (cnt < len) begin
      w = mem_m[a];
      if (w[8]) break;
      exp_q.push_back(w);
      a = (a + 1) % DEPTH;
      cnt++;
      case (w[7:6])
        2'b00: ref_r[w[5:3]] = ref_r[w[2:0]];
        2'b01: begin
          exp_q.push_back(mem_m[a]);
          ref_r[w[5:3]] = mem_m[a];
          a = (a + 1) % DEPTH;
          cnt++;
        end
        2'b10:   ref_r[w[5:3]] = ref_r[w[5:3]] + ref_r[w[2:0]];
        default: ref_r[w[5:3]] = ref_r[w[5:3]] - ref_r[w[2:0]];
      endcase
    end
    exp_pc = a;
  endtask

  task automatic launch(input int len);
    plan(len);
    prog_len = (AW+1)'(len);
    start    = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    int n;
    n = 0;
    while (busy && n < BOUND) begin
      tick();
      n++;
    end
    check({tag, "_ends_in_bound"}, (n < BOUND) ? 32'd1 : 32'd0, 32'd1);
    check({tag, "_halted"}, 32'(halted), 32'd1);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    check({tag, "_all_issued"}, 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_r%0d", tag, i), 32'(preg[i]), 32'(ref_r[i]));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_din"}, 32'(DIN), 32'd0);
    check({tag, "_run"}, 32'(Run), 32'd0);
    check({tag, "_pc"}, 32'(pc), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  function automatic logic [15:0] rand_word();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return {7'd0, 1'b1, 8'($urandom)};
    else if (r < 4) return 16'($urandom);
    else return {7'd0, 1'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
  endfunction

  initial begin
    #900000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n;
    n_checks = 0;
    n_fail = 0;
    mon_en = 1'b0;
    hold_done_low = 1'b0;
    Resetn = 1'b0;
    start = 1'b0;
    load_en = 1'b0;
    load_addr = '0;
    load_data = 16'h0000;
    prog_len = '0;

    // 1: reset
    tick();
    tick();
    check_reset_state("t1_rst");
    Resetn = 1'b1;
    reset_refs();
    mon_en = 1'b1;

    // 2: mvi/mvi/add
    load_word(0, 16'h0040); load_word(1, 16'h0005); load_word(2, 16'h0048);
    load_word(3, 16'h0003); load_word(4, 16'h0081);
    launch(5);
    finish_run("t2");
    check("t2_r0_is_8", 32'(preg[0]), 32'd8);
    check("t2_r1_is_3", 32'(preg[1]), 32'd3);

    // 3: sub and mv; last word written in the start cycle; start while busy ignored
    load_word(0, 16'h0040); load_word(1, 16'h0009); load_word(2, 16'h0048);
    load_word(3, 16'h0004); load_word(4, 16'h00C1);
    mem_m[5] = 16'h0010;
    plan(6);
    load_en = 1'b1; load_addr = AW'(5); load_data = 16'h0010;
    prog_len = (AW+1)'(6); start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    tick(); tick();
    prog_len = (AW+1)'(1); start = 1'b1;
    tick();
    start = 1'b0;
    finish_run("t3");
    check("t3_r0_is_5", 32'(preg[0]), 32'd5);
    check("t3_r2_is_5", 32'(preg[2]), 32'd5);

    // 4: HALT marker stops after two words
    load_word(0, 16'h0040); load_word(1, 16'h0007); load_word(2, 16'h0100); load_word(3, 16'h0048);
    launch(4);
    finish_run("t4");
    check("t4_pc_is_2", 32'(pc), 32'd2);
    check("t4_r0_is_7", 32'(preg[0]), 32'd7);
    check("t4_r1_unchanged", 32'(preg[1]), 32'd4);

    // 5: ARM holds without Done; add without Done times out after 4 WAIT cycles
    load_word(0, 16'h0081);
    hold_done_low = 1'b1;
    launch(1);
    repeat (10) tick();
    check("t5_arm_busy", 32'(busy), 32'd1);
    check("t5_arm_no_error", 32'(error), 32'd0);
    hold_done_low = 1'b0;
    n = 0;
    while (!Run && n < 20) begin tick(); n++; end
    check("t5_issue_seen", (n < 20) ? 32'd1 : 32'd0, 32'd1);
    hold_done_low = 1'b1;
    n = 0;
    while (!error && n < 20) begin tick(); n++; end
    check("t5_error_latency", 32'(n), 32'd5);
    check("t5_busy_cleared", 32'(busy), 32'd0);
    check("t5_not_halted", 32'(halted), 32'd0);
    check("t5_all_issued", 32'(exp_q.size()), 32'd0);
    hold_done_low = 1'b0;

    // 6: load while busy ignored, reset mid add, clean rerun from kept memory
    load_word(0, 16'h0040); load_word(1, 16'h0005); load_word(2, 16'h0048);
    load_word(3, 16'h0003); load_word(4, 16'h0081);
    launch(5);
    check("t6_busy_at_load", 32'(busy), 32'd1);
    load_en = 1'b1; load_addr = AW'(0); load_data = 16'hFFFF;
    tick(); tick();
    load_en = 1'b0;
    n = 0;
    while (!(Run && DIN == 16'h0081) && n < 100) begin tick(); n++; end
    check("t6_add_seen", (n < 100) ? 32'd1 : 32'd0, 32'd1);
    tick();
    Resetn = 1'b0;
    tick(); tick();
    check_reset_state("t6_rst");
    Resetn = 1'b1;
    reset_refs();
    launch(5);
    finish_run("t6");
    check("t6_r0_is_8", 32'(preg[0]), 32'd8);
    check("t6_r1_is_3", 32'(preg[1]), 32'd3);

    // 7: boundaries - mvi overshoots prog_len, zero length, pc wrap
    load_word(0, 16'h0040); load_word(1, 16'h1234);
    launch(1);
    finish_run("t7a");
    check("t7a_pc_is_2", 32'(pc), 32'd2);
    check("t7a_r0", 32'(preg[0]), 32'h1234);
    launch(0);
    finish_run("t7b");
    for (int i = 0; i < DEPTH; i++) load_word(i, 16'h000A);
    launch(35);
    finish_run("t7c");
    check("t7c_pc_wrapped", 32'(pc), 32'd3);

    // random programs
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < DEPTH; i++) load_word(i, rand_word());
      launch($urandom_range(0, 45));
      finish_run($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
